// File: rtl/scaler_pkg.sv
// Shared definitions for the scaling sequencer: requester ids, arbiter states
// and the round-robin selection helper.
package scaler_pkg;

  localparam int NREQ  = 3;
  localparam int TAG_W = 2;

  localparam logic [TAG_W-1:0] REQ_ROM  = 2'd0;
  localparam logic [TAG_W-1:0] REQ_DS   = 2'd1;
  localparam logic [TAG_W-1:0] REQ_US   = 2'd2;
  localparam logic [TAG_W-1:0] REQ_NONE = 2'd3;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_OWN  = 1'b1
  } arb_state_e;

  // First requesting id strictly after ptr in order 0->1->2->0, ptr itself last.
  function automatic logic [TAG_W-1:0] next_rr(input logic [TAG_W-1:0] ptr,
                                               input logic [NREQ-1:0]  req);
    logic [TAG_W-1:0] id;
    next_rr = REQ_NONE;
    for (int k = NREQ; k >= 1; k--) begin
      id = TAG_W'((int'(ptr) + k) % NREQ);
      if (req[id]) next_rr = id;
    end
  endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// Read-return tag pipeline: carries {valid, id} of each read beat for RD_LAT
// cycles and decodes it into a one-hot per-requester read-valid.
module rd_tag_pipe
  import scaler_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int ID_W   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_load,
  input  logic [ID_W-1:0] i_id,
  output logic [NREQ-1:0] o_rvalid,
  output logic            o_busy_next
);

  logic [RD_LAT-1:0] r_vld_p;
  logic [ID_W-1:0]   r_id_p [RD_LAT];
  logic [RD_LAT-1:0] w_vld_next;

  always_comb begin
    w_vld_next    = '0;
    w_vld_next[0] = i_load;
    for (int k = 1; k < RD_LAT; k++) w_vld_next[k] = r_vld_p[k-1];
  end

  // Stage boundary: valid bits are control and are cleared on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) r_vld_p <= '0;
    else        r_vld_p <= w_vld_next;
  end

  always_ff @(posedge clk) begin
    r_id_p[0] <= i_id;
    for (int k = 1; k < RD_LAT; k++) r_id_p[k] <= r_id_p[k-1];
  end

  assign o_rvalid    = r_vld_p[RD_LAT-1] ? (NREQ'(1) << r_id_p[RD_LAT-1]) : '0;
  assign o_busy_next = |w_vld_next;

endmodule

// File: rtl/fbuf_port_arbiter.sv
// Round-robin owner of the single frame-buffer BRAM port shared by the ROM
// loader, downscaler and upscaler, with burst capping and tagged read return.
module fbuf_port_arbiter
  import scaler_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_i,
  input  logic [NREQ-1:0]        we_i,
  input  logic [NREQ*ADDR_W-1:0] addr_i,
  input  logic [NREQ*DATA_W-1:0] wdata_i,
  output logic [NREQ-1:0]        gnt_o,
  output logic                   mem_en_o,
  output logic                   mem_we_o,
  output logic [ADDR_W-1:0]      mem_addr_o,
  output logic [DATA_W-1:0]      mem_wdata_o,
  input  logic [DATA_W-1:0]      mem_rdata_i,
  output logic [DATA_W-1:0]      rdata_o,
  output logic [NREQ-1:0]        rvalid_o,
  output logic                   busy_o
);

  localparam int               CNT_W    = $clog2(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  arb_state_e        r_state, w_state_nx;
  logic [TAG_W-1:0]  r_ptr, w_ptr_nx;
  logic [NREQ-1:0]   r_gnt, w_gnt_nx;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nx;
  logic              r_busy;

  logic              w_beat;
  logic              w_rd_load;
  logic              w_pipe_busy_nx;
  logic [TAG_W-1:0]  w_rr_any;
  logic [TAG_W-1:0]  w_rr_other;

  // The grant register is always one-hot of r_ptr when nonzero.
  assign w_beat     = |(r_gnt & req_i);
  assign w_rr_any   = next_rr(r_ptr, req_i);
  assign w_rr_other = next_rr(r_ptr, req_i & ~(NREQ'(1) << r_ptr));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ARB_IDLE;
      r_ptr   <= REQ_US;
      r_gnt   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_ptr   <= w_ptr_nx;
      r_gnt   <= w_gnt_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_ptr_nx   = r_ptr;
    w_gnt_nx   = r_gnt;
    w_cnt_nx   = r_cnt;
    unique case (r_state)
      ARB_IDLE: begin
        if (w_rr_any != REQ_NONE) begin
          w_state_nx = ARB_OWN;
          w_ptr_nx   = w_rr_any;
          w_gnt_nx   = NREQ'(1) << w_rr_any;
          w_cnt_nx   = '0;
        end
      end
      ARB_OWN: begin
        if (!req_i[r_ptr]) begin
          // Release wins over the burst cap; hand straight over if anyone waits.
          w_cnt_nx = '0;
          if (w_rr_any == REQ_NONE) begin
            w_state_nx = ARB_IDLE;
            w_gnt_nx   = '0;
          end else begin
            w_ptr_nx = w_rr_any;
            w_gnt_nx = NREQ'(1) << w_rr_any;
          end
        end else if (r_cnt == CNT_LAST) begin
          w_cnt_nx = '0;
          if (w_rr_other != REQ_NONE) begin
            w_ptr_nx = w_rr_other;
            w_gnt_nx = NREQ'(1) << w_rr_other;
          end
        end else begin
          w_cnt_nx = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nx = ARB_IDLE;
        w_gnt_nx   = '0;
        w_cnt_nx   = '0;
      end
    endcase
  end

  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (w_beat) begin
      mem_en_o    = 1'b1;
      mem_we_o    = we_i[r_ptr];
      mem_addr_o  = addr_i[int'(r_ptr)*ADDR_W +: ADDR_W];
      mem_wdata_o = wdata_i[int'(r_ptr)*DATA_W +: DATA_W];
    end
  end

  assign w_rd_load = w_beat & ~we_i[r_ptr];

  rd_tag_pipe #(
    .RD_LAT (RD_LAT),
    .ID_W   (TAG_W)
  ) u_rd_tag_pipe (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_rd_load),
    .i_id        (r_ptr),
    .o_rvalid    (rvalid_o),
    .o_busy_next (w_pipe_busy_nx)
  );

  // Busy mirrors next-cycle grant and pipeline occupancy so it lines up with gnt_o.
  always_ff @(posedge clk) begin
    if (!rst_n) r_busy <= 1'b0;
    else        r_busy <= (|w_gnt_nx) | w_pipe_busy_nx;
  end

  assign gnt_o   = r_gnt;
  assign busy_o  = r_busy;
  assign rdata_o = mem_rdata_i;

endmodule
